// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the data-cache geometry, state encoding and a line word-select helper.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [3:0]   lc3b_c_offset;

    typedef enum logic [1:0] {
        StIdle,
        StInd2,
        StWriteback,
        StFill
    } d_cache_state_e;

    localparam int unsigned NumSets = 8;

    function automatic lc3b_word line_word(input lc3b_line line, input logic [2:0] word_sel);
        return line[{word_sel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/d_cache_control.sv
// Data-cache sequencer: hit/miss FSM, indirect phase tracking and the pointer register.
module d_cache_control
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     mem_read,
    input  logic     mem_write,
    input  logic     indirect,
    input  logic     hit,
    input  logic     victim_dirty,
    input  lc3b_word lookup_word,
    input  lc3b_word wb_address,
    input  lc3b_word fill_address,
    input  logic     pmem_resp,
    output logic     phase,
    output lc3b_word ptr,
    output logic     lookup_en,
    output logic     mem_resp,
    output logic     data_write,
    output logic     line_fill,
    output logic     pmem_read,
    output logic     pmem_write,
    output lc3b_word pmem_address
);

    d_cache_state_e state_q, state_d;
    logic           phase_q, phase_d;
    lc3b_word       ptr_q, ptr_d;
    logic           pmem_read_q, pmem_read_d;
    logic           pmem_write_q, pmem_write_d;
    lc3b_word       pmem_address_q, pmem_address_d;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        ptr_d          = ptr_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        mem_resp       = 1'b0;
        data_write     = 1'b0;
        line_fill      = 1'b0;
        lookup_en      = (state_q == StIdle && (mem_read || mem_write)) || state_q == StInd2;

        case (state_q)
            StIdle, StInd2: begin
                if (lookup_en) begin
                    if (hit) begin
                        // Phase 1 of LDI/STI is always a plain word read of the pointer.
                        if (indirect && !phase_q) begin
                            state_d = StInd2;
                            phase_d = 1'b1;
                            ptr_d   = lookup_word;
                        end else begin
                            mem_resp   = 1'b1;
                            data_write = mem_write;
                            state_d    = StIdle;
                            phase_d    = 1'b0;
                        end
                    end else if (victim_dirty) begin
                        state_d        = StWriteback;
                        pmem_write_d   = 1'b1;
                        pmem_address_d = wb_address;
                    end else begin
                        state_d        = StFill;
                        pmem_read_d    = 1'b1;
                        pmem_address_d = fill_address;
                    end
                end
            end
            StWriteback: begin
                if (pmem_resp) begin
                    state_d        = StFill;
                    pmem_write_d   = 1'b0;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = fill_address;
                end
            end
            StFill: begin
                if (pmem_resp) begin
                    line_fill   = 1'b1;
                    pmem_read_d = 1'b0;
                    state_d     = phase_q ? StInd2 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            phase_q        <= 1'b0;
            ptr_q          <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            ptr_q          <= ptr_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
        end
    end

    assign phase        = phase_q;
    assign ptr          = ptr_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;

endmodule

// File: rtl/d_cache.sv
// Direct-mapped write-back L1 data cache: 8 sets of 16-byte lines, LDI/STI indirection support.
module d_cache
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    mem_address,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [1:0]     mem_byte_enable,
    input  logic [15:0]    mem_wdata,
    input  logic           indirect,
    output logic [15:0]    mem_rdata,
    output logic           mem_resp,
    output logic [15:0]    pmem_address,
    output logic           pmem_read,
    output logic           pmem_write,
    output logic [127:0]   pmem_wdata,
    input  logic [127:0]   pmem_rdata,
    input  logic           pmem_resp
);

    logic [NumSets-1:0] valid_q;
    logic [NumSets-1:0] dirty_q;
    lc3b_c_tag          tag_q  [NumSets];
    lc3b_line           data_q [NumSets];

    logic        phase, lookup_en, data_write, line_fill, hit, victim_dirty;
    lc3b_word    ptr, lookup_addr, cur_word, merged_word, wb_address, fill_address;
    lc3b_c_tag   tag;
    lc3b_c_index idx;
    logic [2:0]  word_sel;
    lc3b_line    cur_line, write_line;
    logic        unused_addr_lsb;

    // Phase 2 of an indirect access looks up the pointer instead of the MEM-stage address.
    assign lookup_addr     = phase ? ptr : mem_address;
    assign tag             = lookup_addr[15:7];
    assign idx             = lookup_addr[6:4];
    assign word_sel        = lookup_addr[3:1];
    assign unused_addr_lsb = lookup_addr[0];

    assign cur_line     = data_q[idx];
    assign cur_word     = line_word(cur_line, word_sel);
    assign hit          = valid_q[idx] && (tag_q[idx] == tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    assign wb_address   = {tag_q[idx], idx, 4'b0000};
    assign fill_address = {tag, idx, 4'b0000};

    assign merged_word = {mem_byte_enable[1] ? mem_wdata[15:8] : cur_word[15:8],
                          mem_byte_enable[0] ? mem_wdata[7:0]  : cur_word[7:0]};

    always_comb begin
        write_line = cur_line;
        write_line[{word_sel, 4'b0000} +: 16] = merged_word;
    end

    assign mem_rdata  = (lookup_en && hit) ? cur_word : '0;
    assign pmem_wdata = cur_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (data_write) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (line_fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= pmem_rdata;
        end else if (data_write) begin
            data_q[idx] <= write_line;
        end
    end

    d_cache_control u_control (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .indirect     (indirect),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .lookup_word  (cur_word),
        .wb_address   (wb_address),
        .fill_address (fill_address),
        .pmem_resp    (pmem_resp),
        .phase        (phase),
        .ptr          (ptr),
        .lookup_en    (lookup_en),
        .mem_resp     (mem_resp),
        .data_write   (data_write),
        .line_fill    (line_fill),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address)
    );

endmodule

// File: tb/tb_d_cache.sv
// Bench for d_cache: directed vector table, multi-cycle corner sequences, and random traffic
// checked against a flat-memory reference with a line-residency model.
module tb_d_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read, mem_write, indirect;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata, mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [127:0] pmem_wdata, pmem_rdata;

    d_cache dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .indirect        (indirect),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0]  pmem_mem [0:32767];
    logic [15:0]  ref_mem  [0:32767];
    int           res_tag  [0:7];
    int           lat = 1;
    bit           hold_resp = 1'b0;
    int           last_presp_cyc = 0;
    logic [15:0]  last_wb_addr = '0, last_fill_addr = '0;
    logic [127:0] last_wb_data = '0;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic        ind;
        logic        chk;
        logic [15:0] exp;
        int          cycles; // -1: miss expected (two or more wait cycles)
    } vec_t;
    vec_t vecs [15];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    endfunction

    // Predicts hit for the line holding addr, then records that line as resident.
    function automatic bit touch(input logic [15:0] addr);
        bit h;
        h = (res_tag[addr[6:4]] == int'(addr[15:7]));
        res_tag[addr[6:4]] = int'(addr[15:7]);
        return h;
    endfunction

    // Physical memory responder with a programmable latency.
    initial begin
        int cnt;
        int base;
        cnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset || pmem_resp) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if ((pmem_read || pmem_write) && !hold_resp) begin
                check("pmem_excl", pmem_read && pmem_write, 1'b0);
                check("pmem_align", pmem_address[3:0], 4'h0);
                cnt++;
                if (cnt >= lat) begin
                    base = int'(pmem_address[15:1]);
                    if (pmem_write) begin
                        for (int i = 0; i < 8; i++) pmem_mem[base + i] = pmem_wdata[16*i +: 16];
                        last_wb_addr = pmem_address;
                        last_wb_data = pmem_wdata;
                    end else begin
                        for (int i = 0; i < 8; i++) pmem_rdata[16*i +: 16] = pmem_mem[base + i];
                        last_fill_addr = pmem_address;
                    end
                    pmem_resp = 1'b1;
                    last_presp_cyc = cyc;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [15:0] wd, input logic ind,
                          output logic [15:0] rdata, output int cycles, output int rc);
        bit got;
        @(negedge clk);
        mem_address = a; mem_read = rd; mem_write = wr;
        mem_byte_enable = be; mem_wdata = wd; indirect = ind;
        #1;
        cycles = 0; got = 1'b0; rdata = '0; rc = 0;
        while (!got && cycles < 60) begin
            if (mem_resp) begin
                got = 1'b1;
                rdata = mem_rdata;
                rc = cyc;
            end else begin
                @(negedge clk);
                #1;
                cycles++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL access_timeout: addr %0h got no mem_resp, required one", a);
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0; indirect = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [15:0] r;
        int c, rc;
        for (int k = lo; k <= hi; k++) begin
            access(vecs[k].addr, vecs[k].rd, vecs[k].wr, vecs[k].be, vecs[k].wdata,
                   vecs[k].ind, r, c, rc);
            if (vecs[k].chk) check($sformatf("vec%0d_data", k), r, vecs[k].exp);
            if (vecs[k].cycles < 0) check($sformatf("vec%0d_miss", k), c >= 2, 1'b1);
            else check($sformatf("vec%0d_latency", k), c, vecs[k].cycles);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r, exp, p, a, wd;
        logic [1:0]  be;
        int c, rc, n, kind;
        bit h1, h2;

        for (int i = 0; i < 32768; i++) pmem_mem[i] = 16'($urandom);
        pmem_mem[16'h0043] = 16'hBEEF;  // 0x0086
        pmem_mem[16'h0143] = 16'h1111;  // 0x0286
        pmem_mem[16'h0008] = 16'h0300;  // 0x0010
        pmem_mem[16'h0180] = 16'hCAFE;  // 0x0300
        pmem_mem[16'h0202] = 16'h5A5A;  // 0x0404
        pmem_mem[16'h0203] = 16'h7700;  // 0x0406
        pmem_mem[16'h0013] = 16'h2626;  // 0x0026
        pmem_mem[16'h001B] = 16'h3636;  // 0x0036

        vecs[0]  = '{16'h0086, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'hBEEF, -1};
        vecs[1]  = '{16'h0086, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 0};
        vecs[2]  = '{16'h0087, 1'b0, 1'b1, 2'b10, 16'h5500, 1'b0, 1'b0, 16'h0000, 0};
        vecs[3]  = '{16'h0086, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h55EF, 0};
        vecs[4]  = '{16'h0286, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h1111, -1};
        vecs[5]  = '{16'h0010, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'hCAFE, -1};
        vecs[6]  = '{16'h0010, 1'b0, 1'b1, 2'b11, 16'h0404, 1'b0, 1'b0, 16'h0000, 0};
        vecs[7]  = '{16'h0010, 1'b0, 1'b1, 2'b11, 16'h1234, 1'b1, 1'b0, 16'h0000, -1};
        vecs[8]  = '{16'h0404, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h1234, 0};
        vecs[9]  = '{16'h0010, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h1234, 1};
        vecs[10] = '{16'h0404, 1'b0, 1'b1, 2'b00, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 0};
        vecs[11] = '{16'h0404, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h1234, 0};
        vecs[12] = '{16'h0406, 1'b1, 1'b1, 2'b01, 16'h00AB, 1'b0, 1'b0, 16'h0000, 0};
        vecs[13] = '{16'h0406, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h77AB, 0};
        vecs[14] = '{16'h0405, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h1234, 0};

        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0; indirect = 1'b0;
        mem_byte_enable = 2'b11; mem_wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 16'h0000);
        check("rst_mem_rdata", mem_rdata, 16'h0000);
        reset = 1'b0;

        run_vecs(0, 4);
        check("wb1_addr", last_wb_addr, 16'h0080);
        check("wb1_word3", last_wb_data[63:48], 16'h55EF);
        check("wb1_pmem", pmem_mem[16'h0043], 16'h55EF);
        check("wb1_fill_addr", last_fill_addr, 16'h0280);

        run_vecs(5, 14);

        // Evicting the STI target line must write back its merged contents.
        exp = pmem_mem[16'h0602];
        access(16'h0C04, 1'b1, 1'b0, 2'b11, 16'h0, 1'b0, r, c, rc);
        check("sti_evict_data", r, exp);
        check("sti_wb_addr", last_wb_addr, 16'h0400);
        check("sti_wb_word2", last_wb_data[47:32], 16'h1234);
        check("sti_wb_word3", last_wb_data[63:48], 16'h77AB);

        // Clean miss: mem_resp exactly one cycle after the fill response.
        lat = 3;
        access(16'h0026, 1'b1, 1'b0, 2'b11, 16'h0, 1'b0, r, c, rc);
        check("cold_data", r, 16'h2626);
        check("cold_fill_addr", last_fill_addr, 16'h0020);
        check("cold_resp_cycle", rc, last_presp_cyc + 1);
        lat = 1;

        // Reset in the middle of a fill.
        @(negedge clk);
        hold_resp = 1'b1;
        mem_address = 16'h0036; mem_byte_enable = 2'b11; mem_read = 1'b1;
        n = 0;
        while (!pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstfill_started", pmem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rstfill_pmem_read_drop", pmem_read, 1'b0);
        check("rstfill_mem_resp", mem_resp, 1'b0);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        hold_resp = 1'b0;
        access(16'h0036, 1'b1, 1'b0, 2'b11, 16'h0, 1'b0, r, c, rc);
        check("rstfill_remiss", c >= 2, 1'b1);
        check("rstfill_data", r, 16'h3636);

        // Random traffic: cache contents were discarded by the reset, so memory is the truth.
        for (int i = 0; i < 32768; i++) ref_mem[i] = pmem_mem[i];
        for (int s = 0; s < 8; s++) res_tag[s] = -1;
        for (int t = 0; t < 300; t++) begin
            lat  = $urandom_range(1, 3);
            kind = $urandom_range(0, 4);
            a    = 16'($urandom_range(0, 16'h03FF));
            be   = 2'($urandom);
            wd   = 16'($urandom);
            case (kind)
                0: begin
                    exp = ref_mem[a[15:1]];
                    h1 = touch(a);
                    access(a, 1'b1, 1'b0, 2'b11, wd, 1'b0, r, c, rc);
                    check($sformatf("rnd%0d_rd_data", t), r, exp);
                    if (h1) check($sformatf("rnd%0d_rd_lat", t), c, 0);
                    else check($sformatf("rnd%0d_rd_miss", t), c >= 2, 1'b1);
                end
                1, 2: begin
                    ref_mem[a[15:1]] = merge(ref_mem[a[15:1]], wd, be);
                    h1 = touch(a);
                    access(a, kind == 2, 1'b1, be, wd, 1'b0, r, c, rc);
                    if (h1) check($sformatf("rnd%0d_wr_lat", t), c, 0);
                    else check($sformatf("rnd%0d_wr_miss", t), c >= 2, 1'b1);
                end
                default: begin
                    p  = ref_mem[a[15:1]];
                    h1 = touch(a);
                    h2 = touch(p);
                    if (kind == 3) begin
                        exp = ref_mem[p[15:1]];
                        access(a, 1'b1, 1'b0, be, wd, 1'b1, r, c, rc);
                        check($sformatf("rnd%0d_ldi_data", t), r, exp);
                    end else begin
                        ref_mem[p[15:1]] = merge(ref_mem[p[15:1]], wd, be);
                        access(a, 1'b0, 1'b1, be, wd, 1'b1, r, c, rc);
                    end
                    if (h1 && h2) check($sformatf("rnd%0d_ind_lat", t), c, 1);
                    else check($sformatf("rnd%0d_ind_miss", t), c >= 2, 1'b1);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_cache.md
# d_cache

Direct-mapped, write-back, write-allocate L1 data cache sitting directly downstream of the pipeline MEM stage. Serves the MEM-stage word/byte port (including LDI/STI indirection) and fills/evicts 128-bit lines over the physical-memory port. Hits resolve with zero wait states; misses stall the pipeline via `mem_resp` low.

## Interface
Parameters: none. Fixed geometry is 8 sets × 16-byte lines. Address split:
- tag = addr[15:7]
- index = addr[6:4]
- word offset = addr[3:1]

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- mem_address  in  16  byte address from MEM stage
- mem_read  in  1  read request, held until `mem_resp`
- mem_write  in  1  write request, held until `mem_resp`
- mem_byte_enable  in  2  active-high byte lanes [1]=high byte, [0]=low byte
- mem_wdata  in  16  store data
- indirect  in  1  request is LDI/STI: the word at `mem_address` is the effective address
- mem_rdata  out  16  word at the effective address's word offset
- mem_resp  out  1  single-cycle completion strobe
- pmem_address  out  16  line address, addr[3:0]=0
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_wdata  out  128  evicted line
- pmem_rdata  in  128  fill line
- pmem_resp  in  1  physical memory completion

## Operation
- Per set: valid, dirty, 9-bit tag, 128-bit data. Reset clears valid and dirty; tag and data are don't-care.
- States: IDLE, IND2, WRITEBACK, FILL. The `phase` bit records whether the pending lookup is phase 1 or phase 2 of an indirect access.
- Lookup address:
  - in IDLE: `mem_address`
  - in IND2: `ptr`, the 16-bit register loaded in phase 1
- Hit condition: valid[idx] and tag[idx] == lookup tag.
- IDLE/IND2, read hit (or indirect phase 1 hit): return the word at offset on `mem_rdata`.
  - Non-indirect or phase 2: `mem_resp`=1 the same cycle; next state IDLE.
  - Indirect phase 1: load `ptr` ← word, go to IND2, `mem_resp`=0. Phase 1 is always a word read, whatever `mem_write` or `mem_byte_enable` say.
- Write hit (non-indirect, or phase 2):
  - Each enabled byte lane of the word at offset ← `mem_wdata` lane.
  - Set dirty, `mem_resp`=1, next state IDLE.
  - Enable 2'b00 still responds and sets dirty.
- Miss:
  - Victim valid and dirty → WRITEBACK.
  - Otherwise → FILL.
  - The phase is preserved.
- WRITEBACK:
  - `pmem_write`=1, `pmem_address`={old tag, idx, 4'b0}, `pmem_wdata`=line.
  - On `pmem_resp` → FILL.
- FILL:
  - `pmem_read`=1, `pmem_address`={lookup tag, idx, 4'b0}.
  - On `pmem_resp`: line ← `pmem_rdata`, tag ← lookup tag, valid=1, dirty=0; return to IDLE (phase 1) or IND2 (phase 2), where the access now hits.
- Word access ignores addr[0]. Byte lane selection comes solely from `mem_byte_enable`.
- `mem_read` and `mem_write` both high is illegal; the block treats it as a write.
- No request in IDLE: no state change, all strobes 0.

## Timing
- Reset values:
  - `mem_resp`=0, `pmem_read`=0, `pmem_write`=0.
  - `pmem_address`=0, `mem_rdata`=0.
  - state=IDLE, `ptr`=0.
- Reset asserted mid-miss: pmem strobes drop asynchronously and the partial access is abandoned. The line is not marked valid.
- Hit latency: 0 cycles. `mem_resp` and `mem_rdata` are combinational from the request in the same cycle.
- `mem_resp` is high for exactly one cycle per request. The requester drops or changes its request the next cycle.
- Indirect hit/hit: `mem_resp` in the 2nd cycle.
- Clean miss: `mem_resp` 1 cycle after the fill `pmem_resp`.
- Dirty miss: writeback completes before the fill begins. `pmem_read` and `pmem_write` are never both high.
- pmem strobes stay asserted and address/wdata stay stable until `pmem_resp`. Both strobes deassert in the cycle after `pmem_resp`.
- Indirect where phase 1 and phase 2 map to the same set: phase 2 may evict the pointer's line. This is legal.

## Structure
- Add to `lc3b_types`: `lc3b_line` [127:0], `lc3b_c_tag` [8:0], `lc3b_c_index` [2:0], `lc3b_c_offset` [3:0].
- Add an FSM state enum in the same package.
- Sub-module `d_cache_control`: FSM and phase/`ptr` sequencing.
- Top level `d_cache` holds the arrays, hit compare, byte merge and muxes.

## Test plan
- Cold read 0x0086 → FILL at 0x0080. `pmem_rdata` word3=0xBEEF gives `mem_rdata`=0xBEEF with `mem_resp` 1 cycle after `pmem_resp`. A repeat read hits with 0-cycle `mem_resp`.
- Byte write 0x55 to 0x0087, enable 2'b10 → word 0x55EF. Line dirty, no pmem traffic.
- Read 0x0286 (same set 0, new tag) → WRITEBACK to 0x0080 with `pmem_wdata` word3=0x55EF, then FILL at 0x0280.
- LDI at 0x0010, whose word is 0x0300 → phase-1 fill of 0x0010, phase-2 fill of 0x0300. Returns word 0x0300 with a single `mem_resp`.
- STI pointer 0x0010 (pointer word 0x0404), data 0x1234, enable 2'b11 → word 0x0404 = 0x1234 and its line is dirty.
- Reset asserted during FILL → `pmem_read` drops immediately. The next read of the same address misses again.
